// File: rtl/tile_hdr_prefetch.sv
// rtl/tile_hdr_prefetch.sv - walks the tile descriptor list in DDR3 and buffers parsed headers in a FIFO
module tile_hdr_prefetch #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [28:0] first_addr,
   input  logic        abort,
   output logic [28:0] rd_addr,
   output logic [7:0]  rd_burstcnt,
   output logic        rd_req,
   input  logic        rd_ack,
   input  logic [63:0] rd_data,
   input  logic        rd_data_valid,
   output logic        hdr_valid,
   input  logic        hdr_ready,
   output logic [28:0] hdr_tile_addr,
   output logic [15:0] hdr_px,
   output logic [15:0] hdr_py,
   output logic [15:0] hdr_count,
   output logic        hdr_last,
   output logic        busy,
   output logic [15:0] tiles_fetched
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_BEAT0, S_BEAT1, S_DONE, S_DRAIN} state_t;

   typedef struct packed {
      logic [28:0] tile_addr;
      logic [15:0] px;
      logic [15:0] py;
      logic [15:0] count;
      logic        last;
   } hdr_t;

   state_t        state;
   logic [28:0]   cur_addr;
   logic [28:0]   next_addr;
   logic [1:0]    drain_left;

   hdr_t          fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] fifo_count_nxt;

   logic          start_ok;
   logic          flush;
   logic          push;
   logic          pop;
   hdr_t          push_entry;
   hdr_t          head;
   logic          unused_bits;

   assign unused_bits = ^rd_data[63:61];

   // Handshake decode and next FIFO occupancy; flush (abort or a fresh start) wins over push/pop
   always_comb begin
      start_ok       = start && !abort && (state == S_IDLE || state == S_DONE);
      flush          = abort || start_ok;
      push           = (state == S_BEAT1) && rd_data_valid && !abort;
      pop            = hdr_valid && hdr_ready && !flush;
      push_entry     = {cur_addr, rd_data[31:16], rd_data[47:32], rd_data[15:0], (next_addr == 29'd0)};
      fifo_count_nxt = fifo_count;
      if (flush)
         fifo_count_nxt = '0;
      else if (push && !pop)
         fifo_count_nxt = fifo_count + 1'b1;
      else if (pop && !push)
         fifo_count_nxt = fifo_count - 1'b1;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         fifo_count <= fifo_count_nxt;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Header storage; contents are only visible while hdr_valid so no reset is needed
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= push_entry;
   end

   // List walker: one burst outstanding, request only issued when a push slot is guaranteed
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         rd_req        <= 1'b0;
         cur_addr      <= '0;
         next_addr     <= '0;
         drain_left    <= '0;
         tiles_fetched <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start_ok) begin
                  cur_addr      <= first_addr;
                  tiles_fetched <= '0;
                  rd_req        <= 1'b1;
                  state         <= S_REQ;
               end else if (abort) begin
                  state <= S_IDLE;
               end
            end
            S_REQ: begin
               if (abort) begin
                  rd_req <= 1'b0;
                  if (rd_req && rd_ack) begin
                     drain_left <= 2'd2;
                     state      <= S_DRAIN;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (rd_req && rd_ack) begin
                  rd_req <= 1'b0;
                  state  <= S_BEAT0;
               end else if (!rd_req && fifo_count_nxt < FULL_CNT) begin
                  rd_req <= 1'b1;
               end
            end
            S_BEAT0: begin
               if (abort) begin
                  drain_left <= rd_data_valid ? 2'd1 : 2'd2;
                  state      <= S_DRAIN;
               end else if (rd_data_valid) begin
                  next_addr <= rd_data[60:32];
                  state     <= S_BEAT1;
               end
            end
            S_BEAT1: begin
               if (abort) begin
                  if (rd_data_valid) begin
                     state <= S_IDLE;
                  end else begin
                     drain_left <= 2'd1;
                     state      <= S_DRAIN;
                  end
               end else if (rd_data_valid) begin
                  if (tiles_fetched != 16'hFFFF)
                     tiles_fetched <= tiles_fetched + 16'd1;
                  if (next_addr == 29'd0) begin
                     state <= S_DONE;
                  end else begin
                     cur_addr <= next_addr;
                     rd_req   <= (fifo_count_nxt < FULL_CNT);
                     state    <= S_REQ;
                  end
               end
            end
            S_DRAIN: begin
               if (rd_data_valid) begin
                  drain_left <= drain_left - 2'd1;
                  if (drain_left <= 2'd1)
                     state <= S_IDLE;
               end
            end
            default: begin
               rd_req <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign head          = fifo_mem[rd_ptr];
   assign hdr_valid     = (fifo_count != '0);
   assign hdr_tile_addr = hdr_valid ? head.tile_addr : 29'd0;
   assign hdr_px        = hdr_valid ? head.px : 16'd0;
   assign hdr_py        = hdr_valid ? head.py : 16'd0;
   assign hdr_count     = hdr_valid ? head.count : 16'd0;
   assign hdr_last      = hdr_valid && head.last;
   assign rd_addr       = cur_addr;
   assign rd_burstcnt   = 8'd2;
   assign busy          = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_tile_hdr_prefetch.sv
// tb/tb_tile_hdr_prefetch.sv - randomized self-checking bench for tile_hdr_prefetch
module tb_tile_hdr_prefetch;

   typedef logic [77:0] hdr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [28:0] first_addr;
   logic        abort;
   logic [28:0] rd_addr;
   logic [7:0]  rd_burstcnt;
   logic        rd_req;
   logic        rd_ack;
   logic [63:0] rd_data;
   logic        rd_data_valid;
   logic        hdr_valid;
   logic        hdr_ready;
   logic [28:0] hdr_tile_addr;
   logic [15:0] hdr_px;
   logic [15:0] hdr_py;
   logic [15:0] hdr_count;
   logic        hdr_last;
   logic        busy;
   logic [15:0] tiles_fetched;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          ready_mode = 0;
   int          ack_fixed = -1;
   int          bursts = 0;
   logic        ready_reg;
   logic        beat1_now;
   logic        resp_active;
   logic [63:0] b0 [logic [28:0]];
   logic [63:0] b1 [logic [28:0]];
   hdr_t        exp_q [$];

   always #5 clk = ~clk;

   assign hdr_ready = (ready_mode == 3) ? (rd_data_valid && beat1_now) : ready_reg;

   tile_hdr_prefetch #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .first_addr(first_addr), .abort(abort),
      .rd_addr(rd_addr), .rd_burstcnt(rd_burstcnt), .rd_req(rd_req), .rd_ack(rd_ack),
      .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_tile_addr(hdr_tile_addr),
      .hdr_px(hdr_px), .hdr_py(hdr_py), .hdr_count(hdr_count), .hdr_last(hdr_last),
      .busy(busy), .tiles_fetched(tiles_fetched)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic hdr_t obs_hdr();
      return {hdr_tile_addr, hdr_px, hdr_py, hdr_count, hdr_last};
   endfunction

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   // Linked list in the DDR model plus the header sequence a correct walker must deliver
   task automatic build_list(input int n, output logic [28:0] first);
      logic [28:0] addrs [$];
      logic [28:0] a;
      logic [28:0] nxt;
      logic [15:0] px, py, cnt;
      b0.delete();
      b1.delete();
      for (int i = 0; i < n; i++) begin
         do a = 29'($urandom_range(1, 29'h1FFFFFFF)); while (b0.exists(a));
         b0[a] = 64'd0;
         addrs.push_back(a);
      end
      for (int i = 0; i < n; i++) begin
         nxt = (i == n - 1) ? 29'd0 : addrs[i + 1];
         px  = 16'($urandom);
         py  = 16'($urandom);
         cnt = 16'($urandom);
         b0[addrs[i]] = {3'($urandom), nxt, 32'($urandom)};
         b1[addrs[i]] = {16'($urandom), py, px, cnt};
         exp_q.push_back({addrs[i], px, py, cnt, (i == n - 1)});
      end
      first = addrs[0];
   endtask

   task automatic pulse_start(input logic [28:0] f);
      first_addr = f;
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_req", 128'(rd_req), 128'd1);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin step(); n++; end
      check(tag, 128'(n < budget), 128'd1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin step(); n++; end
      check(tag, 128'(n < budget), 128'd1);
   endtask

   task automatic wait_tf(input logic [15:0] v, input int budget);
      int n = 0;
      while (tiles_fetched != v && n < budget) begin step(); n++; end
      check("wait_tf", 128'(n < budget), 128'd1);
   endtask

   // DDR3 arbiter slot model: random ack delay, two beats with random gaps
   initial begin : ddr
      logic [28:0] a;
      int d;
      rd_ack = 1'b0; rd_data_valid = 1'b0; rd_data = '0; beat1_now = 1'b0; resp_active = 1'b0;
      forever begin
         @(negedge clk);
         rd_ack = 1'b0; rd_data_valid = 1'b0; beat1_now = 1'b0; resp_active = 1'b0;
         if (rd_req === 1'b1 && !reset) begin
            a = rd_addr;
            d = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
            for (int i = 0; i < d && rd_req; i++) @(negedge clk);
            if (rd_req) begin
               check("rd_addr_known", 128'(b0.exists(a)), 128'd1);
               check("burstcnt", 128'(rd_burstcnt), 128'd2);
               rd_ack = 1'b1;
               resp_active = 1'b1;
               bursts++;
               @(negedge clk);
               rd_ack = 1'b0;
               check("req_drop_after_ack", 128'(rd_req), 128'd0);
               for (int b = 0; b < 2; b++) begin
                  repeat ($urandom_range(0, 2)) @(negedge clk);
                  rd_data = b0.exists(a) ? (b == 0 ? b0[a] : b1[a]) : 64'd0;
                  rd_data_valid = 1'b1;
                  beat1_now = (b == 1);
                  @(negedge clk);
                  rd_data_valid = 1'b0;
                  beat1_now = 1'b0;
                  rd_data = 64'($urandom) << 32;
               end
               resp_active = 1'b0;
            end
         end
      end
   end

   // Consumer: compares every pop against the model queue and checks head stability under stall
   initial begin : consumer
      hdr_t prev;
      logic held;
      ready_reg = 1'b0;
      held = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         #3;
         if (hdr_valid) begin
            if (held)
               check("hdr_stable", 128'(obs_hdr()), 128'(prev));
            if (hdr_ready) begin
               check("pop_expected", 128'(exp_q.size() != 0), 128'd1);
               if (exp_q.size() != 0) begin
                  check("hdr_order", 128'(obs_hdr()), 128'(exp_q[0]));
                  void'(exp_q.pop_front());
               end
               held = 1'b0;
            end else begin
               held = 1'b1;
               prev = obs_hdr();
            end
         end else begin
            held = 1'b0;
         end
         @(posedge clk);
         #1;
         case (ready_mode)
            1:       ready_reg = 1'b1;
            2:       ready_reg = 1'($urandom);
            default: ready_reg = 1'b0;
         endcase
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
      $fatal(1);
   end

   initial begin : main
      logic [28:0] f;
      int base;
      int n;
      reset = 1'b1; start = 1'b0; abort = 1'b0; first_addr = '0;
      repeat (3) step();
      check("rst_rd_req", 128'(rd_req), 128'd0);
      check("rst_rd_addr", 128'(rd_addr), 128'd0);
      check("rst_burstcnt", 128'(rd_burstcnt), 128'd2);
      check("rst_hdr_valid", 128'(hdr_valid), 128'd0);
      check("rst_hdr_data", 128'(obs_hdr()), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_tiles", 128'(tiles_fetched), 128'd0);
      reset = 1'b0;
      step();

      // three-tile list, consumer always ready, fixed ack delay
      ready_mode = 1; ack_fixed = 2;
      build_list(3, f);
      pulse_start(f);
      wait_done("three_done", 1000);
      check("three_tiles", 128'(tiles_fetched), 128'd3);
      check("three_busy", 128'(busy), 128'd0);
      check("three_req", 128'(rd_req), 128'd0);
      check("three_empty", 128'(hdr_valid), 128'd0);
      ack_fixed = -1;

      // single tile with known fields
      b0.delete(); b1.delete();
      b0[29'h06100000] = {3'd0, 29'd0, 32'd0};
      b1[29'h06100000] = {16'd0, 16'd48, 16'd32, 16'd500};
      exp_q.push_back({29'h06100000, 16'd32, 16'd48, 16'd500, 1'b1});
      pulse_start(29'h06100000);
      wait_done("single_done", 500);
      check("single_tiles", 128'(tiles_fetched), 128'd1);

      // backpressure: FIFO of 4 fills, walker stops requesting
      ready_mode = 0;
      build_list(8, f);
      base = bursts;
      pulse_start(f);
      repeat (150) step();
      check("bp_bursts", 128'(bursts - base), 128'd4);
      check("bp_req_low", 128'(rd_req), 128'd0);
      check("bp_valid", 128'(hdr_valid), 128'd1);
      check("bp_tiles", 128'(tiles_fetched), 128'd4);
      ready_mode = 2;
      wait_done("bp_done", 3000);
      check("bp_tiles_all", 128'(tiles_fetched), 128'd8);
      check("bp_bursts_all", 128'(bursts - base), 128'd8);

      // simultaneous push and pop with 3 of 4 entries held
      ready_mode = 0;
      build_list(8, f);
      pulse_start(f);
      wait_tf(16'd3, 500);
      ready_mode = 3;
      wait_idle("pp_idle", 2000);
      check("pp_tiles", 128'(tiles_fetched), 128'd8);
      check("pp_left", 128'(exp_q.size()), 128'd3);
      check("pp_valid", 128'(hdr_valid), 128'd1);
      ready_mode = 1;
      wait_done("pp_drain", 500);

      // abort on the cycle beat 0 of the second burst arrives
      ready_mode = 0;
      build_list(4, f);
      pulse_start(f);
      wait_tf(16'd1, 500);
      n = 0;
      while (!(rd_data_valid && !beat1_now) && n < 200) begin step(); n++; end
      check("ab_beat0_seen", 128'(n < 200), 128'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      exp_q.delete();
      check("ab_draining", 128'(busy), 128'd1);
      check("ab_flushed", 128'(hdr_valid), 128'd0);
      wait_idle("ab_idle", 100);
      check("ab_beat1_consumed", 128'(resp_active), 128'd0);
      check("ab_no_push", 128'(tiles_fetched), 128'd1);
      check("ab_valid", 128'(hdr_valid), 128'd0);
      repeat (4) step();
      check("ab_req_low", 128'(rd_req), 128'd0);
      ready_mode = 1;
      build_list(3, f);
      pulse_start(f);
      wait_done("ab_restart", 1000);
      check("ab_restart_tiles", 128'(tiles_fetched), 128'd3);

      // abort and start together while in S_DONE with entries buffered
      ready_mode = 0;
      build_list(2, f);
      pulse_start(f);
      wait_idle("as_done", 500);
      check("as_valid", 128'(hdr_valid), 128'd1);
      abort = 1'b1; start = 1'b1; first_addr = f;
      step();
      abort = 1'b0; start = 1'b0;
      exp_q.delete();
      check("as_busy", 128'(busy), 128'd0);
      check("as_flushed", 128'(hdr_valid), 128'd0);
      base = bursts;
      repeat (5) step();
      check("as_req_low", 128'(rd_req), 128'd0);
      check("as_no_burst", 128'(bursts - base), 128'd0);

      // randomized lists with random backpressure and arbiter timing
      for (int r = 0; r < 6; r++) begin
         n = int'($urandom_range(1, 7));
         ready_mode = 2;
         build_list(n, f);
         pulse_start(f);
         wait_done("rnd_done", 3000);
         check("rnd_tiles", 128'(tiles_fetched), 128'(n));
         check("rnd_empty", 128'(hdr_valid), 128'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tile_hdr_prefetch.md
# tile_hdr_prefetch

Walks the per-frame tile descriptor linked list in DDR3 ahead of dispatch and buffers the parsed tile headers in a small FIFO. The coordinator pops ready headers and dispatches them to cores without a DDR3 round-trip per tile. Its read port attaches to one requestor slot of the DDR3 arbiter. It uses the same rd_req/rd_ack/rd_data_valid protocol as the gsplat cores.

## Interface
Parameters:
- DEPTH, 4: header FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begin walking the list at first_addr. Honoured only in S_IDLE or S_DONE.
- first_addr  in  29  qword address of the first tile descriptor; sampled when start is accepted.
- abort  in  1  one-cycle pulse; discard the list and FIFO, return to S_IDLE.
- rd_addr  out  29  qword read address.
- rd_burstcnt  out  8  always 2.
- rd_req  out  1  read request; held until rd_ack.
- rd_ack  in  1  request accepted (arbiter).
- rd_data  in  64  read beat.
- rd_data_valid  in  1  read beat strobe.
- hdr_valid  out  1  FIFO head entry valid.
- hdr_ready  in  1  consumer pops the head when hdr_valid && hdr_ready.
- hdr_tile_addr  out  29  descriptor address of the head entry.
- hdr_px, hdr_py, hdr_count  out  16 each  tile x, tile y and splat count of the head entry.
- hdr_last  out  1  head entry is the final tile of the list.
- busy  out  1  FSM is not in S_IDLE or S_DONE.
- tiles_fetched  out  16  headers pushed since start; saturates at 16'hFFFF.

## Operation
- Descriptor layout:
  - Beat 0 [60:32] = next descriptor qword address; 0 terminates the list.
  - Beat 1 [15:0] = splat count, [31:16] = px, [47:32] = py.
- FSM states:
  - S_IDLE: wait for start. On start, latch cur_addr = first_addr, clear the FIFO and tiles_fetched, go to S_REQ.
  - S_REQ: when fifo_count < DEPTH, drive rd_req=1 with rd_addr=cur_addr. On rd_ack, drop rd_req the next cycle and go to S_BEAT0.
  - S_BEAT0: on rd_data_valid, latch next = rd_data[60:32] and go to S_BEAT1.
  - S_BEAT1: on rd_data_valid, push {cur_addr, px, py, count, last=(next==0)} into the FIFO and increment tiles_fetched. If next==0, go to S_DONE; else set cur_addr=next and go to S_REQ.
  - S_DONE: list fully fetched; the FIFO continues to drain. start re-arms.
  - S_DRAIN: entered on abort while in S_BEAT0 or S_BEAT1, or when abort coincides with rd_ack in S_REQ. Consume the remaining beats of the outstanding burst (count them), then go to S_IDLE.
- At most one burst is outstanding. The space check in S_REQ guarantees a push never meets a full FIFO.
- abort:
  - Flushes the FIFO in the same cycle.
  - In S_REQ without rd_ack, or in S_DONE, go directly to S_IDLE with rd_req=0.
  - Abort has priority over start in the same cycle.
- A start pulse while busy is ignored.
- Pop and push in the same cycle are both performed; fifo_count is unchanged.

## Timing
- Reset values:
  - Outputs: rd_req=0, rd_addr=0, rd_burstcnt=2, hdr_valid=0, hdr_last=0, hdr_* data=0, busy=0, tiles_fetched=0.
  - Internal: state=S_IDLE, FIFO empty.
- Reset mid-burst returns to S_IDLE. Stray rd_data_valid beats in S_IDLE, S_REQ or S_DONE are ignored.
- start accepted at cycle N: rd_req=1 at N+1.
- rd_ack at cycle M: rd_req=0 at M+1.
- Push on beat 1 at cycle K: hdr_valid=1 at K+1 (registered FIFO, show-ahead head).
- Back-to-back tiles: the next rd_req is asserted the cycle after the push, when space allows.
- Pop at cycle P: the next entry is visible at P+1, or hdr_valid=0 at P+1 if the FIFO is empty.
- hdr_* outputs are stable while hdr_valid && !hdr_ready.

## Test plan
- Three-tile list: A→B→C, next(C)=0, hdr_ready=1, ack after 2 cycles. Expect 3 pops with tile_addr A,B,C, hdr_last=1 only on C, tiles_fetched=3, FSM in S_DONE, busy=0.
- Single tile: first_addr=0x06100000, next=0, px=32, py=48, count=500. Expect one entry with exactly those fields and last=1.
- Backpressure: 8-tile list, DEPTH=4, hdr_ready=0. Expect exactly 4 bursts issued, rd_req held 0 afterwards, hdr_valid=1. Raise hdr_ready: the remaining 4 are fetched in order with no loss or duplicate.
- Abort mid-burst: abort on the cycle beat 0 arrives. Expect beat 1 consumed in S_DRAIN, no push, then S_IDLE with hdr_valid=0. A new start then fetches correctly.
- Abort with start in the same cycle while in S_DONE: expect S_IDLE and no rd_req. A later start is accepted.
- Simultaneous push and pop with FIFO at 3 of 4: expect fifo_count to stay 3 and FIFO order preserved.
